motion_sequencer: RTL and testbench

Parametrised instruction sequencer for the robot controller: records up to DEPTH switch-set instructions, then replays them one per timed step. Unlike the current FSM/FIFO/countdown trio, playback is non-destructive, so a program can be re-run, looped, paused or aborted without re-entry. Sits between the debounced KEY pulses/SW inputs and the torque/direction display decoders, replacing the FSM, fifo and countdown instances.

---
 rtl/seq_pkg.sv | 41 ++++
 rtl/step_timer.sv | 44 ++++
 rtl/motion_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_motion_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the motion sequencer: playback states and the ranking
// used to pick one command when several pulses arrive in the same cycle.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // A larger value means a higher priority.
    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_SAVE    = 3'd1,
        CMD_DELETE  = 3'd2,
        CMD_EXECUTE = 3'd3,
        CMD_ABORT   = 3'd4,
        CMD_CLEAR   = 3'd5
    } cmd_t;

    function automatic cmd_t pick_cmd(input logic clear, input logic abort,
                                      input logic execute, input logic delete,
                                      input logic save);
        cmd_t c;
        if (clear) begin
            c = CMD_CLEAR;
        end else if (abort) begin
            c = CMD_ABORT;
        end else if (execute) begin
            c = CMD_EXECUTE;
        end else if (delete) begin
            c = CMD_DELETE;
        end else if (save) begin
            c = CMD_SAVE;
        end else begin
            c = CMD_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Per-step down-counter: counts only while run is high and reloads itself on
// the terminal cycle so consecutive steps need no extra load.
module step_timer #(
    parameter int TICKS = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic done
);
    localparam int TW = $clog2(TICKS);
    localparam logic [TW-1:0] RELOAD = TW'(TICKS - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise count down (with reload) only while running.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (run) begin
            if (cnt_q == {TW{1'b0}}) begin
                cnt_d = RELOAD;
            end else begin
                cnt_d = cnt_q - TW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {TW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = run && (cnt_q == {TW{1'b0}});

endmodule

// File: rtl/motion_sequencer.sv
// Records switch-set instructions and replays them non-destructively, one per
// timed step, with pause/resume, abort and optional looping.
module motion_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_W     = 5,
    parameter int STEP_TICKS = 50_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       save,
    input  logic                       delete,
    input  logic                       execute,
    input  logic                       abort,
    input  logic                       clear,
    input  logic                       loop_mode,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          cmd_out,
    output logic                       cmd_valid,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic [1:0]                 state,
    output logic                       err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] cmd_out_q, cmd_out_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    cmd_t cmd_s;
    logic wr_en_s, is_last_s, timer_load_s, timer_run_s, timer_done_s;

    step_timer #(.TICKS(STEP_TICKS)) u_step_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load_s),
        .run  (timer_run_s),
        .done (timer_done_s)
    );

    // Next-state, storage-control and output decode.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        count_d      = count_q;
        err_d        = 1'b0;
        wr_en_s      = 1'b0;
        timer_load_s = 1'b0;
        timer_run_s  = (state_q == RUN);
        cmd_s        = pick_cmd(clear, abort, execute, delete, save);
        is_last_s    = (step_q == IDX_W'(count_q - CNT_W'(1)));

        case (state_q)
            IDLE: begin
                case (cmd_s)
                    CMD_CLEAR: count_d = {CNT_W{1'b0}};
                    CMD_EXECUTE: begin
                        if (count_q != {CNT_W{1'b0}}) begin
                            state_d      = RUN;
                            step_d       = {IDX_W{1'b0}};
                            timer_load_s = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    CMD_DELETE: begin
                        if (count_q == {CNT_W{1'b0}}) begin
                            err_d = 1'b1;
                        end else begin
                            count_d = count_q - CNT_W'(1);
                        end
                    end
                    CMD_SAVE: begin
                        if (count_q == CNT_W'(DEPTH)) begin
                            err_d = 1'b1;
                        end else begin
                            wr_en_s = 1'b1;
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
            RUN: begin
                // Step advance happens regardless of the command that also acts.
                if (timer_done_s) begin
                    if (!is_last_s) begin
                        step_d = step_q + IDX_W'(1);
                    end else if (loop_mode) begin
                        step_d = {IDX_W{1'b0}};
                    end else begin
                        state_d = IDLE;
                        step_d  = {IDX_W{1'b0}};
                    end
                end else begin
                    step_d = step_q;
                end
                case (cmd_s)
                    CMD_CLEAR, CMD_DELETE, CMD_SAVE: err_d = 1'b1;
                    CMD_ABORT: begin
                        state_d = IDLE;
                        step_d  = {IDX_W{1'b0}};
                    end
                    CMD_EXECUTE: begin
                        if (state_d == RUN) begin
                            state_d = PAUSE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    default: err_d = 1'b0;
                endcase
            end
            PAUSE: begin
                case (cmd_s)
                    CMD_CLEAR, CMD_DELETE, CMD_SAVE: err_d = 1'b1;
                    CMD_ABORT: begin
                        state_d = IDLE;
                        step_d  = {IDX_W{1'b0}};
                    end
                    CMD_EXECUTE: state_d = RUN;
                    default: state_d = PAUSE;
                endcase
            end
            default: begin
                state_d = IDLE;
                step_d  = {IDX_W{1'b0}};
            end
        endcase

        cmd_valid_d = (state_d != IDLE);
        if (cmd_valid_d) begin
            cmd_out_d = mem_q[step_d];
        end else begin
            cmd_out_d = {DATA_W{1'b0}};
        end
        empty_d = (count_d == {CNT_W{1'b0}});
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // State, storage and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= {IDX_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            cmd_out_q   <= {DATA_W{1'b0}};
            cmd_valid_q <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            count_q     <= count_d;
            cmd_out_q   <= cmd_out_d;
            cmd_valid_q <= cmd_valid_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            err_q       <= err_d;
            if (wr_en_s) begin
                mem_q[IDX_W'(count_q)] <= data_in;
            end
        end
    end

    assign cmd_out   = cmd_out_q;
    assign cmd_valid = cmd_valid_q;
    assign step_idx  = step_q;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign state     = state_q;
    assign err       = err_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer with DEPTH=4, DATA_W=5, STEP_TICKS=4.
module tb_motion_sequencer;
    logic       clk = 1'b0;
    logic       rst, save, delete, execute, abort, clear, loop_mode;
    logic [4:0] data_in;
    logic [4:0] cmd_out;
    logic       cmd_valid, empty, full, err;
    logic [1:0] step_idx, state;
    logic [2:0] count;

    int tests_run = 0;
    int tests_failed = 0;

    motion_sequencer #(.DEPTH(4), .DATA_W(5), .STEP_TICKS(4)) dut (
        .clk(clk), .rst(rst), .save(save), .delete(delete), .execute(execute),
        .abort(abort), .clear(clear), .loop_mode(loop_mode), .data_in(data_in),
        .cmd_out(cmd_out), .cmd_valid(cmd_valid), .step_idx(step_idx),
        .count(count), .empty(empty), .full(full), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are then stable and all command pulses are dropped.
    task automatic cyc();
        @(posedge clk);
        #1;
        save = 1'b0; delete = 1'b0; execute = 1'b0; abort = 1'b0; clear = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd"}, 32'(cmd_out), 32'h0);
        chk({tag, "_valid"}, 32'(cmd_valid), 32'h0);
        chk({tag, "_step"}, 32'(step_idx), 32'h0);
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_empty"}, 32'(empty), 32'h1);
        chk({tag, "_full"}, 32'(full), 32'h0);
        chk({tag, "_state"}, 32'(state), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
    endtask

    logic [4:0] prog3 [3];
    logic [4:0] prog2 [2];

    initial begin
        prog3[0] = 5'h01; prog3[1] = 5'h06; prog3[2] = 5'h0B;
        prog2[0] = 5'h11; prog2[1] = 5'h12;
        rst = 1'b1; save = 1'b0; delete = 1'b0; execute = 1'b0; abort = 1'b0;
        clear = 1'b0; loop_mode = 1'b0; data_in = 5'h00;
        cyc(); cyc();
        rst = 1'b0;
        chk_reset("reset");

        // Basic single-pass playback
        for (int i = 0; i < 3; i++) begin
            save = 1'b1; data_in = prog3[i]; cyc();
        end
        chk("basic_count", 32'(count), 32'd3);
        chk("basic_empty", 32'(empty), 32'h0);
        execute = 1'b1; cyc();
        chk("basic_state_run", 32'(state), 32'd1);
        chk("basic_valid", 32'(cmd_valid), 32'h1);
        for (int s = 0; s < 3; s++) begin
            for (int t = 0; t < 4; t++) begin
                chk($sformatf("basic_cmd_s%0d_t%0d", s, t), 32'(cmd_out), 32'(prog3[s]));
                chk($sformatf("basic_step_s%0d_t%0d", s, t), 32'(step_idx), 32'(s));
                cyc();
            end
        end
        chk("basic_end_state", 32'(state), 32'd0);
        chk("basic_end_cmd", 32'(cmd_out), 32'h0);
        chk("basic_end_valid", 32'(cmd_valid), 32'h0);
        chk("basic_end_step", 32'(step_idx), 32'h0);
        chk("basic_end_count", 32'(count), 32'd3);

        // Full / empty boundaries
        clear = 1'b1; cyc();
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_empty", 32'(empty), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill_full_before_%0d", i), 32'(full), 32'h0);
            save = 1'b1; data_in = 5'(i + 2); cyc();
            chk($sformatf("fill_err_%0d", i), 32'(err), 32'h0);
        end
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_count", 32'(count), 32'd4);
        save = 1'b1; data_in = 5'h1F; cyc();
        chk("overfill_err", 32'(err), 32'h1);
        chk("overfill_count", 32'(count), 32'd4);
        cyc();
        chk("overfill_err_drop", 32'(err), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_empty_before_%0d", i), 32'(empty), 32'h0);
            delete = 1'b1; cyc();
            chk($sformatf("drain_count_%0d", i), 32'(count), 32'(3 - i));
        end
        chk("drain_empty", 32'(empty), 32'h1);
        delete = 1'b1; cyc();
        chk("underflow_err", 32'(err), 32'h1);
        chk("underflow_count", 32'(count), 32'd0);

        // Looping and abort
        for (int i = 0; i < 2; i++) begin
            save = 1'b1; data_in = prog2[i]; cyc();
        end
        loop_mode = 1'b1;
        execute = 1'b1; cyc();
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("loop_step_%0d", k), 32'(step_idx), 32'((k / 4) % 2));
            chk($sformatf("loop_cmd_%0d", k), 32'(cmd_out), 32'(prog2[(k / 4) % 2]));
            cyc();
        end
        chk("loop_still_run", 32'(state), 32'd1);
        cyc();
        abort = 1'b1; cyc();
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_cmd", 32'(cmd_out), 32'h0);
        chk("abort_count", 32'(count), 32'd2);
        execute = 1'b1; cyc();
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_step", 32'(step_idx), 32'd0);
        chk("restart_cmd", 32'(cmd_out), 32'h11);

        // Pause after two ticks of step 0, then resume
        cyc();
        execute = 1'b1; cyc();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("pause_state_%0d", k), 32'(state), 32'd2);
            chk($sformatf("pause_cmd_%0d", k), 32'(cmd_out), 32'h11);
            chk($sformatf("pause_valid_%0d", k), 32'(cmd_valid), 32'h1);
            cyc();
        end
        execute = 1'b1; cyc();
        chk("resume_state", 32'(state), 32'd1);
        chk("resume_tick3_step", 32'(step_idx), 32'd0);
        cyc();
        chk("resume_tick4_step", 32'(step_idx), 32'd0);
        cyc();
        chk("resume_next_step", 32'(step_idx), 32'd1);
        chk("resume_next_cmd", 32'(cmd_out), 32'h12);

        // Rejects and priority
        save = 1'b1; data_in = 5'h1F; cyc();
        chk("run_save_err", 32'(err), 32'h1);
        chk("run_save_count", 32'(count), 32'd2);
        chk("run_save_state", 32'(state), 32'd1);
        abort = 1'b1; cyc();
        chk("abort2_state", 32'(state), 32'd0);
        clear = 1'b1; save = 1'b1; data_in = 5'h07; cyc();
        chk("clr_save_count", 32'(count), 32'd0);
        chk("clr_save_err", 32'(err), 32'h0);
        chk("clr_save_empty", 32'(empty), 32'h1);
        execute = 1'b1; cyc();
        chk("exec_empty_err", 32'(err), 32'h1);
        chk("exec_empty_state", 32'(state), 32'd0);

        // Reset during playback at step 1
        loop_mode = 1'b0;
        save = 1'b1; data_in = 5'h01; cyc();
        save = 1'b1; data_in = 5'h02; cyc();
        execute = 1'b1; cyc();
        cyc(); cyc(); cyc(); cyc();
        chk("prereset_step", 32'(step_idx), 32'd1);
        chk("prereset_cmd", 32'(cmd_out), 32'h02);
        rst = 1'b1; cyc();
        rst = 1'b0;
        chk_reset("midrst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
